// File: rtl/imem_resp.sv
// imem_resp - instruction-memory responder for the imem_if fetch protocol.
//
// Accepts fetch requests, reads a word-addressed instruction RAM in the
// accept cycle, and returns in-order responses a fixed LATENCY cycles later
// through a response FIFO that holds its head stable under backpressure.
// A side write port preloads or patches program contents.
//
// Parameters:
//   DEPTH     - RAM words (power of two, >= 4)
//   LATENCY   - accept-to-earliest-response cycles (1..4)
//   QDEPTH    - maximum in-flight requests (>= LATENCY+1 for full rate)
//   FILL_WORD - power-up content of every word
//
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake, req_addr is a byte address
//   resp_valid/resp_ready - response handshake, resp_data is the word
//   wr_en/wr_addr/wr_data - RAM write port (word index)
//   inflight              - accepted but undelivered requests
//   addr_fault            - sticky misaligned/out-of-range flag (only with
//                           IMEM_ADDR_CHECK_EN defined)
//
// Build option: define IMEM_ADDR_CHECK_EN to answer misaligned or
// out-of-range fetches with 32'h00000000 and raise addr_fault. Without it
// the address wraps modulo DEPTH*4.
module imem_resp #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned QDEPTH    = 2,
  parameter logic [31:0] FILL_WORD = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  output logic                      resp_valid,
  output logic [31:0]               resp_data,
  input  logic                      resp_ready,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [31:0]               wr_data,
`ifdef IMEM_ADDR_CHECK_EN
  output logic                      addr_fault,
`endif
  output logic [$clog2(QDEPTH):0]   inflight
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  // Storage keeps (word ^ FILL_WORD): an all-zero power-up image therefore
  // reads back as FILL_WORD everywhere, and reset never touches it.
  logic [31:0]   mem_r [DEPTH];

  logic          accept_s;
  logic          deliver_s;
  logic [AW-1:0] word_idx_s;
  logic [31:0]   fetch_data_s;
  logic          push_valid_s;
  logic [31:0]   push_data_s;

  logic [31:0]   fifo_mem_r [QDEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] fifo_count_r;

  logic [CW-1:0] inflight_r;
  logic [CW-1:0] inflight_nxt_s;
  logic          ready_r;
  logic          unused_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(QDEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PW'(1'b1);
    end
  endfunction

  assign word_idx_s = req_addr[AW+1:2];
  // ready_r tracks inflight < QDEPTH one edge early; reset_n gating keeps
  // ready low during reset and high from the first cycle after it.
  assign req_ready  = reset_n & ready_r;
  assign accept_s   = req_valid & req_ready;
  assign resp_valid = (fifo_count_r != '0);
  assign deliver_s  = resp_valid & resp_ready;
  assign inflight   = inflight_r;

  // Low address bits and upper bits are only inspected by the fault check.
  assign unused_s = ^{req_addr[1:0], req_addr[31:AW+2]};

`ifdef IMEM_ADDR_CHECK_EN
  logic addr_bad_s;
  logic addr_fault_r;

  assign addr_bad_s   = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign fetch_data_s = addr_bad_s ? 32'h0000_0000 : (mem_r[word_idx_s] ^ FILL_WORD);
  assign addr_fault   = addr_fault_r;

  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_fault_r <= 1'b0;
    end else if (accept_s && addr_bad_s) begin
      addr_fault_r <= 1'b1;
    end else begin
      addr_fault_r <= addr_fault_r;
    end
  end
`else
  assign fetch_data_s = mem_r[word_idx_s] ^ FILL_WORD;
`endif

  // RAM write port; a same-cycle fetch already read the old word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data ^ FILL_WORD;
    end
  end

  // Read-result pipeline: the FIFO write is the last of the LATENCY
  // register stages, so only LATENCY-1 extra stages sit in front of it.
  generate
    if (LATENCY > 1) begin : g_pipe
      localparam int unsigned NS = LATENCY - 1;
      logic [NS-1:0] stg_valid_r;
      logic [31:0]   stg_data_r [NS];

      // Stage valid chain, flushed by reset
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          stg_valid_r <= '0;
        end else begin
          stg_valid_r[0] <= accept_s;
          for (int i = 1; i < NS; i++) begin
            stg_valid_r[i] <= stg_valid_r[i-1];
          end
        end
      end

      // Stage data chain, qualified by the valid chain
      always_ff @(posedge clk) begin
        stg_data_r[0] <= fetch_data_s;
        for (int i = 1; i < NS; i++) begin
          stg_data_r[i] <= stg_data_r[i-1];
        end
      end

      assign push_valid_s = stg_valid_r[NS-1];
      assign push_data_s  = stg_data_r[NS-1];
    end else begin : g_nopipe
      assign push_valid_s = accept_s;
      assign push_data_s  = fetch_data_s;
    end
  endgenerate

  // Next in-flight count from this cycle's accept and delivery
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({accept_s, deliver_s})
      2'b10:   inflight_nxt_s = inflight_r + CW'(1'b1);
      2'b01:   inflight_nxt_s = inflight_r - CW'(1'b1);
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // In-flight counter and registered request-ready
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inflight_r <= '0;
      ready_r    <= 1'b1;
    end else begin
      inflight_r <= inflight_nxt_s;
      ready_r    <= (inflight_nxt_s < CW'(QDEPTH));
    end
  end

  // Response FIFO pointers and occupancy; inflight bounds it to QDEPTH
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
    end else begin
      if (push_valid_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (deliver_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_valid_s, deliver_s})
        2'b10:   fifo_count_r <= fifo_count_r + CW'(1'b1);
        2'b01:   fifo_count_r <= fifo_count_r - CW'(1'b1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // Response FIFO storage, qualified by fifo_count_r
  always_ff @(posedge clk) begin
    if (push_valid_s) begin
      fifo_mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Head of FIFO drives the response; forced to zero when not valid
  always_comb begin
    resp_data = 32'h0000_0000;
    if (resp_valid) begin
      resp_data = fifo_mem_r[rd_ptr_r];
    end else begin
      resp_data = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_imem_resp.sv
// Self-checking bench for imem_resp: a directed vector table covering the
// basic fetch, back-to-back, backpressure, read-before-write, reset and
// address-wrap/fault cases, then randomized traffic against a queue model.
module tb_imem_resp;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 1;
  localparam int QDEPTH  = 2;
  localparam logic [31:0] FILL = 32'h0000_0013;
  localparam logic [31:0] WA   = 32'h0050_0093;
  localparam logic [31:0] WB   = 32'h0070_0113;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  inflight;
`ifdef IMEM_ADDR_CHECK_EN
  logic        addr_fault;
`endif

  always #5 clk = ~clk;

  imem_resp #(.DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH), .FILL_WORD(FILL)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef IMEM_ADDR_CHECK_EN
    .addr_fault(addr_fault),
`endif
    .inflight(inflight)
  );

  // Reference model: program image, pending responses with due cycle.
  typedef struct { logic [31:0] data; int due; } pend_t;
  pend_t       pend_q[$];
  logic [31:0] mem_m [DEPTH];
  logic        fault_m;
  int          cyc;
  int          n_cmp;
  int          n_fail;

  typedef struct {
    logic rst; logic rv; logic [31:0] addr; logic rr; logic we; logic [7:0] wa; logic [31:0] wd;
    logic e_rdy; logic e_vld; logic [31:0] e_data; logic [1:0] e_inf;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic rv, input logic [31:0] addr, input logic rr,
                     input logic we, input logic [7:0] wa, input logic [31:0] wd,
                     input logic er, input logic ev, input logic [31:0] ed, input logic [1:0] ei);
    vecs.push_back('{rst, rv, addr, rr, we, wa, wd, er, ev, ed, ei});
  endtask

  task automatic drive(input logic rst, input logic rv, input logic [31:0] addr, input logic rr,
                       input logic we, input logic [7:0] wa, input logic [31:0] wd);
    reset_n = rst; req_valid = rv; req_addr = addr; resp_ready = rr;
    wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
  endtask

  // Compare DUT against the model, then advance the model across the edge.
  task automatic step();
    logic        exp_rdy;
    logic        exp_vld;
    logic [31:0] exp_data;
    int          idx;
    exp_rdy  = reset_n && (pend_q.size() < QDEPTH);
    exp_vld  = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    exp_data = exp_vld ? pend_q[0].data : 32'h0;
    chk("req_ready", {31'h0, req_ready}, {31'h0, exp_rdy});
    chk("resp_valid", {31'h0, resp_valid}, {31'h0, exp_vld});
    chk("resp_data", resp_data, exp_data);
    chk("inflight", {30'h0, inflight}, 32'(pend_q.size()));
`ifdef IMEM_ADDR_CHECK_EN
    chk("addr_fault", {31'h0, addr_fault}, {31'h0, fault_m});
`endif
    if (!reset_n) begin
      pend_q.delete();
      fault_m = 1'b0;
    end else begin
      if (exp_vld && resp_ready) void'(pend_q.pop_front());
      if (req_valid && exp_rdy) begin
        idx = int'((req_addr >> 2) % 32'(DEPTH));
`ifdef IMEM_ADDR_CHECK_EN
        if ((req_addr % 32'd4 != 32'd0) || (req_addr >= 32'(DEPTH * 4))) begin
          pend_q.push_back('{32'h0, cyc + LATENCY});
          fault_m = 1'b1;
        end else begin
          pend_q.push_back('{mem_m[idx], cyc + LATENCY});
        end
`else
        pend_q.push_back('{mem_m[idx], cyc + LATENCY});
`endif
      end
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] x400;
    logic [31:0] x2;
    n_cmp = 0; n_fail = 0; cyc = 0; fault_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = FILL;
`ifdef IMEM_ADDR_CHECK_EN
    x400 = 32'h0; x2 = 32'h0;
`else
    x400 = WA; x2 = WA;
`endif
    //  rst rv addr        rr we wa     wd        rdy vld data  inf
    add(0, 0, 32'h0,     0, 0, 8'd0, 32'h0,    0, 0, 32'h0, 2'd0);
    add(0, 0, 32'h0,     0, 0, 8'd0, 32'h0,    0, 0, 32'h0, 2'd0);
    add(1, 0, 32'h0,     0, 1, 8'd0, WA,       1, 0, 32'h0, 2'd0);
    add(1, 0, 32'h0,     0, 1, 8'd1, WB,       1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 1, WA,    2'd1);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h4,     1, 0, 8'd0, 32'h0,    1, 1, WA,    2'd1);
    add(1, 1, 32'h8,     1, 0, 8'd0, 32'h0,    1, 1, WB,    2'd1);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 1, FILL,  2'd1);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h0,     0, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h4,     0, 0, 8'd0, 32'h0,    1, 1, WA,    2'd1);
    add(1, 1, 32'h8,     0, 0, 8'd0, 32'h0,    0, 1, WA,    2'd2);
    add(1, 0, 32'h0,     0, 0, 8'd0, 32'h0,    0, 1, WA,    2'd2);
    add(1, 0, 32'h0,     0, 0, 8'd0, 32'h0,    0, 1, WA,    2'd2);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    0, 1, WA,    2'd2);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 1, WB,    2'd1);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h4,     1, 1, 8'd1, WD,       1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h4,     1, 0, 8'd0, 32'h0,    1, 1, WB,    2'd1);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 1, WD,    2'd1);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h0,     0, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h4,     0, 0, 8'd0, 32'h0,    1, 1, WA,    2'd1);
    add(0, 0, 32'h0,     0, 0, 8'd0, 32'h0,    0, 1, WA,    2'd2);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 1, WA,    2'd1);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 1, 32'h400,   1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 1, x400,  2'd1);
    add(1, 1, 32'h2,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 1, x2,    2'd1);
    add(1, 0, 32'h0,     1, 0, 8'd0, 32'h0,    1, 0, 32'h0, 2'd0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].rv, vecs[k].addr, vecs[k].rr, vecs[k].we, vecs[k].wa, vecs[k].wd);
      chk("tab_ready", {31'h0, req_ready}, {31'h0, vecs[k].e_rdy});
      chk("tab_valid", {31'h0, resp_valid}, {31'h0, vecs[k].e_vld});
      chk("tab_data", resp_data, vecs[k].e_data);
      chk("tab_inflight", {30'h0, inflight}, {30'h0, vecs[k].e_inf});
      step();
    end
`ifdef IMEM_ADDR_CHECK_EN
    chk("tab_addr_fault", {31'h0, addr_fault}, 32'h1);
`endif

    // Randomized traffic with occasional resets, writes and wild addresses.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      drive($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, a,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            8'($urandom_range(0, 255)), $urandom());
      step();
    end

    // Drain outstanding responses within a bounded number of cycles.
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8'd0, 32'h0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
# imem_resp

Synthesizable instruction-memory responder for the `imem_if` fetch protocol, serving the CPU fetch unit from the responder end. It accepts fetch requests, reads a word-addressed instruction RAM, and returns in-order responses after a fixed pipeline latency. Responses hold under backpressure. A side write port preloads or patches program contents. It replaces behavioural fetch models and sits between `cpu_top` and the boot/loader logic.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥4.
- `LATENCY`, 1: cycles from request acceptance to earliest `resp_valid`; range 1..4.
- `QDEPTH`, 2: maximum in-flight requests (accepted, not yet delivered); must be ≥ `LATENCY`+1 for full throughput.
- `FILL_WORD`, 32'h00000013: initial content of every word (NOP).
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `imem.req_valid` in 1: fetch request valid.
- `imem.req_ready` out 1: request can be accepted this cycle.
- `imem.req_addr` in 32: byte address of the fetch.
- `imem.resp_valid` out 1: response word valid.
- `imem.resp_data` out 32: fetched instruction word.
- `imem.resp_ready` in 1: consumer takes the response this cycle.
- `wr_en` in 1: preload/patch write strobe.
- `wr_addr` in log2(DEPTH): word index for the write.
- `wr_data` in 32: word to write.
- `inflight` out log2(QDEPTH)+1: count of accepted, undelivered requests.

## Operation
- Accept occurs when `req_valid && req_ready`. `req_ready = (inflight < QDEPTH)` is registered-state based and does not depend combinationally on `req_valid`.
- Word index is `req_addr[log2(DEPTH)+1:2]`. The RAM is read in the accept cycle, so the returned data is the content at acceptance.
- The read result enters a `LATENCY`-stage shift pipeline, then a response FIFO of `QDEPTH` entries. The FIFO head drives `resp_valid`/`resp_data`.
- Delivery occurs when `resp_valid && resp_ready`; the FIFO pops.
- While `resp_valid=1` and `resp_ready=0`, `resp_data` is held bit-stable.
- Responses are strictly in request order. No reordering and no dropping outside reset.
- `inflight`:
  - +1 on accept, −1 on delivery.
  - Unchanged when both occur in the same cycle.
  - Never exceeds `QDEPTH`.
- Write port: `wr_en` writes `wr_data` at `wr_addr` at the clock edge.
  - When a write and an accept hit the same word in the same cycle, the fetch returns the old data (read-before-write).
- RAM contents start at `FILL_WORD` and are not altered by reset.
- Reset (`reset_n=0` at an edge): pipeline and FIFO are flushed and `inflight=0`. Any in-flight requests are discarded and never answered.

## Timing
- Reset values: `req_ready=0` while `reset_n=0`. After reset, `req_ready=1` from the first cycle with `reset_n=1`. `resp_valid=0`, `resp_data=0`, `inflight=0`.
- Accept at edge T: `resp_valid=1` and data visible after edge T+`LATENCY`, provided the FIFO ahead is empty.
- With `req_valid` and `resp_ready` held high and `QDEPTH` ≥ `LATENCY`+1: one accept and one delivery per cycle, sustained.
- FIFO full with a simultaneous pop: an accept in the same cycle is allowed only if `inflight<QDEPTH` at the start of the cycle. There is no combinational ready-through from `resp_ready`.
- `resp_data` is 0 whenever `resp_valid=0`.

## Configuration
- `IMEM_ADDR_CHECK_EN`:
  - Defined: a request with `req_addr[1:0]!=0`, or with `req_addr[31:log2(DEPTH)+2]!=0`, is accepted and returns 32'h00000000 (illegal instruction) in order. It also sets output `addr_fault` (1 bit, sticky, cleared only by reset).
  - Undefined: `addr_fault` is absent. Low two bits are ignored and upper bits are dropped, so the address wraps modulo `DEPTH`*4.

## Test plan
- Preload word 0=32'h00500093 and word 1=32'h00700113. Single request addr 0x0 with `resp_ready=1` → `resp_valid` after exactly 1 cycle, data 32'h00500093, `inflight` returns to 0.
- Back-to-back requests 0x0, 0x4, 0x8 on consecutive cycles with `resp_ready=1` → three consecutive `resp_valid` cycles with data 00500093, 00700113, 00000013.
- Two requests, then `resp_ready=0` for 4 cycles → `req_ready=0` at `inflight=2`; `resp_data` holds 00500093 stable. After `resp_ready` rises, both words are delivered in order.
- Same cycle: `wr_en` to index 1 with 32'hDEADBEEF, and accept of addr 0x4 → response 00700113. The next fetch of 0x4 returns DEADBEEF.
- Reset asserted with 2 requests in flight → no `resp_valid` ever appears for them. After reset, `inflight=0`, `req_ready=1`, and a fresh fetch of 0x0 returns 00500093.
- With `IMEM_ADDR_CHECK_EN`: fetch 0x2 → data 00000000, `addr_fault`=1. Fetch 0x400 (DEPTH=256) → data 00000000. Without the macro, 0x400 returns word 0.
